csa_addsub_pipe: RTL

//   Parametrised, pipelined carry-select add/subtract unit; successor to the fixed 64-bit CSA top.

---
 rtl/csa_addsub_pipe.sv | 132 +++++++++++++
 1 files changed

// File: rtl/csa_addsub_pipe.sv
// Pipelined carry-select add/subtract with optional accumulator; result STAGES cycles after accept.
// One op per cycle, no output backpressure; ready drops only while an accumulate op is in flight.
module csa_addsub_pipe #(
  parameter int WIDTH  = 64,
  parameter int BLOCK  = 8,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic             ready,
  input  logic             add_sub,
  input  logic             acc_mode,
  input  logic             acc_clr,
  input  logic [WIDTH-1:0] ope1,
  input  logic [WIDTH-1:0] ope2,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overf,
  output logic             complete
);

  localparam int NBLK = WIDTH / BLOCK;
  localparam int BPS  = (NBLK + STAGES - 1) / STAGES;
  localparam int LAST = STAGES - 1;
  localparam logic [BLOCK:0] ONE = {{BLOCK{1'b0}}, 1'b1};

  generate
    if (WIDTH % BLOCK != 0) begin : g_bad_block
      $error("csa_addsub_pipe: WIDTH must be a multiple of BLOCK");
    end
    if (STAGES < 1 || STAGES > NBLK) begin : g_bad_stages
      $error("csa_addsub_pipe: STAGES must be in 1..WIDTH/BLOCK");
    end
  endgenerate

  logic [WIDTH-1:0]  acc;
  logic [WIDTH-1:0]  r_a   [STAGES];
  logic [WIDTH-1:0]  r_b   [STAGES];
  logic [WIDTH-1:0]  r_sum [STAGES];
  logic [STAGES-1:0] r_c, r_vld, r_acc;
  logic              r_ovf;

  logic [WIDTH-1:0]  n_a   [STAGES];
  logic [WIDTH-1:0]  n_b   [STAGES];
  logic [WIDTH-1:0]  n_sum [STAGES];
  logic [STAGES-1:0] n_c, n_vld, n_acc;
  logic              n_ovf;
  logic              take;

  // Blocking any new op while an accumulate op is in flight avoids reading a stale acc.
  assign ready = ~|(r_vld & r_acc);
  assign take  = start & ready;

  always_comb begin
    logic [WIDTH-1:0] ca, cb, cs;
    logic             cc;
    logic [BLOCK:0]   s0, s1, blk;
    int               p;
    ca    = '0;
    cb    = '0;
    cs    = '0;
    cc    = 1'b0;
    s0    = '0;
    s1    = '0;
    blk   = '0;
    p     = 0;
    n_c   = '0;
    n_vld = '0;
    n_acc = '0;
    for (int s = 0; s < STAGES; s++) begin
      p  = (s == 0) ? 0 : s - 1;
      ca = (s == 0) ? (acc_mode ? acc : ope1) : r_a[p];
      cb = (s == 0) ? (add_sub ? ~ope2 : ope2) : r_b[p];
      cs = (s == 0) ? '0 : r_sum[p];
      cc = (s == 0) ? add_sub : r_c[p];
      n_vld[s] = (s == 0) ? take : r_vld[p];
      n_acc[s] = (s == 0) ? acc_mode : r_acc[p];
      for (int j = 0; j < NBLK; j++) begin
        if (j / BPS == s) begin
          // Both carry-in cases precomputed; the incoming block carry picks one.
          s0  = {1'b0, ca[j*BLOCK +: BLOCK]} + {1'b0, cb[j*BLOCK +: BLOCK]};
          s1  = {1'b0, ca[j*BLOCK +: BLOCK]} + {1'b0, cb[j*BLOCK +: BLOCK]} + ONE;
          blk = cc ? s1 : s0;
          cs[j*BLOCK +: BLOCK] = blk[BLOCK-1:0];
          cc  = blk[BLOCK];
        end
      end
      n_a[s]   = ca;
      n_b[s]   = cb;
      n_sum[s] = cs;
      n_c[s]   = cc;
    end
    n_ovf = (n_a[LAST][WIDTH-1] == n_b[LAST][WIDTH-1]) &&
            (n_sum[LAST][WIDTH-1] != n_a[LAST][WIDTH-1]);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < STAGES; s++) begin
        r_a[s]   <= '0;
        r_b[s]   <= '0;
        r_sum[s] <= '0;
      end
      r_c   <= '0;
      r_vld <= '0;
      r_acc <= '0;
      r_ovf <= 1'b0;
      acc   <= '0;
    end else begin
      r_vld <= n_vld;
      for (int s = 0; s < STAGES; s++) begin
        if (n_vld[s]) begin
          r_a[s]   <= n_a[s];
          r_b[s]   <= n_b[s];
          r_sum[s] <= n_sum[s];
          r_c[s]   <= n_c[s];
          r_acc[s] <= n_acc[s];
        end
      end
      if (n_vld[LAST]) r_ovf <= n_ovf;
      if (acc_clr) acc <= '0;
      else if (n_vld[LAST] && n_acc[LAST]) acc <= n_sum[LAST];
    end
  end

  assign sum      = r_sum[LAST];
  assign cout     = r_c[LAST];
  assign overf    = r_ovf;
  assign complete = r_vld[LAST];

endmodule
